// File: rtl/wave_shaper_if.sv
// wave_shaper_if: phase-in / sample-out bundle between the phase accumulator,
// the wave shaper and its sample consumer.
interface wave_shaper_if #(parameter int PHASE_W = 16);
   logic [PHASE_W-1:0] i_phase;
   logic               i_phase_valid;
   logic [1:0]         i_wave_sel;
   logic [PHASE_W-1:0] i_pulse_width;
   logic [PHASE_W-1:0] o_sample;
   logic               o_sample_valid;
   modport master (output i_phase, i_phase_valid, i_wave_sel, i_pulse_width, input o_sample, o_sample_valid);
   modport slave (input i_phase, i_phase_valid, i_wave_sel, i_pulse_width, output o_sample, o_sample_valid);
endinterface

// File: rtl/wave_shaper.sv
// wave_shaper: 3-stage phase-to-sample shaper (saw, pulse, triangle, quarter-wave sine)
// with shape and pulse width latched only on phase wrap.
module wave_shaper #(
   parameter int PHASE_W  = 16,
   parameter int LUT_BITS = 8
) (
   input logic          i_clk5MHz,
   input logic          i_rst_n,
   wave_shaper_if.slave bus
);
   localparam int DEPTH = 2 ** LUT_BITS;
   localparam logic [PHASE_W-1:0] MSB   = {1'b1, {(PHASE_W-1){1'b0}}};
   localparam logic [PHASE_W-1:0] MAX_P = ~MSB;
   // Taylor series keeps the table generator free of math library calls.
   function automatic logic [PHASE_W-1:0] sin_entry(input int k);
      real x, term, s;
      x = 3.14159265358979323846 * (real'(k) + 0.5) / (2.0 * real'(DEPTH));
      term = x;
      s = x;
      for (int n = 1; n < 12; n++) begin
         term = -term * x * x / real'((2 * n) * (2 * n + 1));
         s += term;
      end
      return PHASE_W'($rtoi(real'(MAX_P) * s + 0.5));
   endfunction
   logic [PHASE_W-1:0] lut [DEPTH];
   for (genvar k = 0; k < DEPTH; k++) begin : g_lut
      localparam logic [PHASE_W-1:0] E = sin_entry(k);
      assign lut[k] = E;
   end
   logic [PHASE_W-1:0] r_last_phase, r_pw, pw_n, tri_t, shape, mag, s2_val, s2_rom;
   logic [1:0]         r_sel, sel_n;
   logic [LUT_BITS-1:0] idx;
   logic r_armed, latch, s1_valid, s2_valid, s2_sine, s2_neg;
   // r_last_phase doubles as the S1 phase register; r_sel/r_pw always describe that sample.
   always_comb begin
      latch = bus.i_phase_valid && (!r_armed || bus.i_phase < r_last_phase);
      sel_n = latch ? bus.i_wave_sel : r_sel;
      pw_n  = latch ? bus.i_pulse_width : r_pw;
      tri_t = r_last_phase[PHASE_W-1] ? ~{r_last_phase[PHASE_W-2:0], 1'b0} : {r_last_phase[PHASE_W-2:0], 1'b0};
      shape = r_sel == 2'b00 ? r_last_phase ^ MSB :
              r_sel == 2'b01 ? (r_last_phase < r_pw ? MAX_P : MSB) : tri_t ^ MSB;
      idx   = r_last_phase[PHASE_W-3 -: LUT_BITS] ^ {LUT_BITS{r_last_phase[PHASE_W-2]}};
      mag   = s2_sine ? s2_rom : s2_val;
   end
   always_ff @(posedge i_clk5MHz or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last_phase       <= '0;
         r_armed            <= 1'b0;
         r_sel              <= 2'b00;
         r_pw               <= MSB;
         s1_valid           <= 1'b0;
         s2_valid           <= 1'b0;
         s2_val             <= '0;
         s2_rom             <= '0;
         s2_sine            <= 1'b0;
         s2_neg             <= 1'b0;
         bus.o_sample       <= '0;
         bus.o_sample_valid <= 1'b0;
      end else begin
         s1_valid <= bus.i_phase_valid;
         if (bus.i_phase_valid) begin
            r_last_phase <= bus.i_phase;
            r_armed      <= 1'b1;
            r_sel        <= sel_n;
            r_pw         <= pw_n;
         end
         s2_valid           <= s1_valid;
         s2_val             <= shape;
         s2_rom             <= lut[idx];
         s2_sine            <= r_sel == 2'b11;
         s2_neg             <= r_sel == 2'b11 && r_last_phase[PHASE_W-1];
         bus.o_sample_valid <= s2_valid;
         if (s2_valid) bus.o_sample <= s2_neg ? -mag : mag;
      end
   end
endmodule
